// File: rtl/wave_capture.sv
// wave_capture: arms on a positive zero crossing and writes 256 samples into the hidden RAM half, then flips read_index when the display is idle (in: clk, reset, new_sample_ready, new_sample_in, wave_display_idle; out: write_address, write_enable, write_sample, read_index)
module wave_capture #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);
  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;
  state_t     r_state, w_next;
  logic       r_prev_neg;
  logic [7:0] r_count, w_count;
  logic       w_we, w_ri, w_trig, w_unused;
  logic [7:0] w_data;
  assign w_trig   = new_sample_ready & r_prev_neg & ~new_sample_in[SAMPLE_W-1];
  assign w_data   = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
  assign w_unused = ^new_sample_in[SAMPLE_W-9:0];
  always_comb begin
    w_next  = r_state;
    w_count = r_count;
    w_we    = 1'b0;
    w_ri    = read_index;
    case (r_state)
      ARMED: if (w_trig) begin
        w_we    = 1'b1;
        w_count = r_count + 8'd1;
        w_next  = ACTIVE;
      end
      ACTIVE: if (new_sample_ready) begin
        w_we    = 1'b1;
        w_count = r_count + 8'd1;
        w_next  = (r_count == 8'hFF) ? WAIT : ACTIVE;
      end
      WAIT: if (wave_display_idle) begin
        w_ri    = ~read_index;
        w_count = 8'd0;
        w_next  = ARMED;
      end
      default: w_next = ARMED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ARMED;
      r_count       <= 8'd0;
      r_prev_neg    <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= 9'd0;
      write_sample  <= 8'd0;
    end else begin
      r_state      <= w_next;
      r_count      <= w_count;
      read_index   <= w_ri;
      write_enable <= w_we;
      if (new_sample_ready) r_prev_neg <= new_sample_in[SAMPLE_W-1];
      if (w_we) begin
        write_address <= {~read_index, r_count};
        write_sample  <= w_data;
      end
    end
  end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed vector table plus hand sequences for capture, flip and mid-capture reset
module tb_wave_capture;
  logic        clk = 1'b0;
  logic        reset, new_sample_ready, wave_display_idle;
  logic [15:0] new_sample_in;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  int          n_checks = 0;
  int          n_fail = 0;
  typedef struct {
    logic        rst, rdy, idle;
    logic [15:0] s;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  data;
    logic        ri;
  } vec_t;
  vec_t vecs[17];
  wave_capture #(.SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_address(write_address), .write_enable(write_enable),
    .write_sample(write_sample), .read_index(read_index)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_out(input string tag, input logic we, input logic [8:0] addr, input logic [7:0] data, input logic ri);
    chk({tag, " write_enable"}, 32'(write_enable), 32'(we));
    chk({tag, " write_address"}, 32'(write_address), 32'(addr));
    chk({tag, " write_sample"}, 32'(write_sample), 32'(data));
    chk({tag, " read_index"}, 32'(read_index), 32'(ri));
  endtask
  task automatic step(input logic rst, input logic rdy, input logic idle, input logic [15:0] s);
    reset = rst;
    new_sample_ready = rdy;
    wave_display_idle = idle;
    new_sample_in = s;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic rst, rdy, idle, input logic [15:0] s, input logic we, input logic [8:0] addr, input logic [7:0] data, input logic ri);
    mk.rst = rst; mk.rdy = rdy; mk.idle = idle; mk.s = s;
    mk.we = we; mk.addr = addr; mk.data = data; mk.ri = ri;
  endfunction
  initial begin
    reset = 1'b1;
    new_sample_ready = 1'b0;
    wave_display_idle = 1'b0;
    new_sample_in = 16'h0;
    vecs[0]  = mk(1, 1, 0, 16'hFFFF, 0, 9'h000, 8'h00, 0);
    vecs[1]  = mk(1, 0, 0, 16'h0000, 0, 9'h000, 8'h00, 0);
    vecs[2]  = mk(0, 1, 0, 16'h0003, 0, 9'h000, 8'h00, 0);
    for (int i = 3; i < 8; i++) vecs[i] = mk(0, 1, 0, 16'h0100, 0, 9'h000, 8'h00, 0);
    vecs[8]  = mk(0, 1, 0, 16'h0001, 0, 9'h000, 8'h00, 0);
    vecs[9]  = mk(0, 1, 0, 16'hFFFF, 0, 9'h000, 8'h00, 0);
    for (int i = 10; i < 13; i++) vecs[i] = mk(0, 1, 0, 16'h8000, 0, 9'h000, 8'h00, 0);
    vecs[13] = mk(0, 1, 0, 16'h0000, 1, 9'h100, 8'h80, 0);
    vecs[14] = mk(0, 0, 1, 16'h0000, 0, 9'h100, 8'h80, 0);
    vecs[15] = mk(0, 1, 0, 16'h7FFF, 1, 9'h101, 8'hFF, 0);
    vecs[16] = mk(0, 0, 0, 16'h0000, 0, 9'h101, 8'hFF, 0);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].idle, vecs[i].s);
      check_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ri);
    end
    for (int k = 2; k < 256; k++) begin
      logic [7:0] b;
      b = 8'(k);
      step(0, 1, 0, {b, 8'h00});
      check_out($sformatf("cap%0d", k), 1'b1, {1'b1, b}, b ^ 8'h80, 1'b0);
    end
    for (int j = 0; j < 10; j++) begin
      step(0, 1, 1'b0, (j < 9) ? 16'h1234 : 16'h8000);
      check_out($sformatf("extra%0d", j), 1'b0, 9'h1FF, 8'h7F, 1'b0);
    end
    for (int j = 0; j < 20; j++) begin
      step(0, 0, 0, 16'h0000);
      chk($sformatf("wait%0d read_index", j), 32'(read_index), 32'd0);
    end
    step(0, 1, 1, 16'h0003);
    check_out("flip", 1'b0, 9'h1FF, 8'h7F, 1'b1);
    step(0, 1, 0, 16'h0005);
    check_out("post_flip_pos", 1'b0, 9'h1FF, 8'h7F, 1'b1);
    step(0, 1, 0, 16'h8000);
    check_out("post_flip_neg", 1'b0, 9'h1FF, 8'h7F, 1'b1);
    step(0, 1, 0, 16'h0003);
    check_out("trig_low_half", 1'b1, 9'h000, 8'h80, 1'b1);
    for (int k = 1; k < 10; k++) begin
      logic [7:0] b;
      b = 8'(k);
      step(0, 1, 0, {b, 8'h00});
      check_out($sformatf("low%0d", k), 1'b1, {1'b0, b}, b ^ 8'h80, 1'b1);
    end
    step(1, 1, 0, 16'h0003);
    check_out("mid_reset", 1'b0, 9'h000, 8'h00, 1'b0);
    step(0, 1, 0, 16'hFFFF);
    check_out("rearm_neg", 1'b0, 9'h000, 8'h00, 1'b0);
    step(0, 1, 0, 16'h0003);
    check_out("retrig", 1'b1, 9'h100, 8'h80, 1'b0);
    step(0, 1, 0, 16'h7FFF);
    check_out("retrig_next", 1'b1, 9'h101, 8'hFF, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
